// File: rtl/care_action_if.sv
// ----------------------------------------------------------------------------
// care_action_if
// Valid/ready channel that carries one caretaker action token from the
// receiver to the plant state logic.
//   act_valid : token available (producer -> consumer)
//   act_id    : action id, meaningful only while act_valid=1
//   act_ready : consumer accepts the token (consumer -> producer)
// ----------------------------------------------------------------------------
interface care_action_if;
  logic       act_valid;
  logic [1:0] act_id;
  logic       act_ready;

  modport master (
    output act_valid,
    output act_id,
    input  act_ready
  );

  modport slave (
    input  act_valid,
    input  act_id,
    output act_ready
  );
endinterface : care_action_if

// File: rtl/care_action_receiver.sv
// ----------------------------------------------------------------------------
// care_action_receiver
// Captures caretaker button presses and delivers them to the plant as
// action tokens. The block synchronises and debounces four raw buttons and
// turns each press into at most one pending token. It offers tokens
// lowest-id-first over a valid/ready channel and enforces a cooldown after
// every delivered token. It also counts presses that had to be discarded.
//
// Ports:
//   clk           : single clock, all state updates on the rising edge
//   rst           : synchronous reset, active-high
//   btn_i[3:0]    : raw asynchronous buttons, index = action id
//                   (0 = poke/wake, 1 = feed, 2 = water, 3 = light)
//   asleep_i      : plant sleep state, synchronous to clk
//   act           : token channel (master side)
//   dropped_o     : one-cycle pulse, at least one press was discarded
//   drop_count_o  : saturating count of discarded presses
//   busy_o        : cooldown active
// ----------------------------------------------------------------------------
module care_action_receiver #(
  parameter int unsigned DB_CYCLES = 8,   // 1..255
  parameter int unsigned COOLDOWN  = 16   // 0..255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          btn_i,
  input  logic                asleep_i,
  care_action_if.master       act,
  output logic                dropped_o,
  output logic [7:0]          drop_count_o,
  output logic                busy_o
);

  typedef enum logic {
    ST_IDLE,   // no token offered
    ST_OFFER   // token offered, id locked until transfer
  } state_e;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN);

  // Synchroniser, debounce and capture state
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] stable_q, stable_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] pending_q, pending_d;

  // Handshake, cooldown and drop bookkeeping
  state_e     state_q, state_d;
  logic [1:0] act_id_q, act_id_d;
  logic [7:0] cd_q, cd_d;
  logic       dropped_q, dropped_d;
  logic [7:0] drop_count_q, drop_count_d;

  // Intermediate combinational terms
  logic       xfer;
  logic [3:0] clr;
  logic [3:0] rise;
  logic [3:0] set;
  logic [2:0] n_drop;
  logic [8:0] drop_sum;

  // Lowest set index of a non-zero pending vector.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred. Combinational blocks use
    // blocking '=' so later lines see the values computed above them.
    sync1_d      = btn_i;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    state_d      = state_q;
    act_id_d     = act_id_q;
    cd_d         = (cd_q != 8'd0) ? cd_q - 8'd1 : cd_q;
    dropped_d    = 1'b0;
    drop_count_d = drop_count_q;
    set          = 4'b0000;
    n_drop       = 3'd0;

    // A transfer happens on this edge if a token is offered and accepted.
    xfer = (state_q == ST_OFFER) && act.act_ready;
    clr  = xfer ? (4'b0001 << act_id_q) : 4'b0000;

    // Debounce: the stable value flips only after the synchronised input has
    // disagreed with it for DB_CYCLES consecutive edges.
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end

    // A press is a 0->1 flip of the debounced state on this edge.
    rise = stable_d & ~stable_q;

    // Capture: sleep blocks everything but poke/wake. A press for an id that
    // is still pending is refused unless that token leaves on this very edge.
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        if (asleep_i && (i != 0)) begin
          n_drop = n_drop + 3'd1;
        end else if (pending_q[i] && !clr[i]) begin
          n_drop = n_drop + 3'd1;
        end else begin
          set[i] = 1'b1;
        end
      end
    end

    // Set beats clear when both hit the same bit.
    pending_d = (pending_q & ~clr) | set;

    // Discard bookkeeping: one pulse per edge, count every discarded press.
    dropped_d    = (n_drop != 3'd0);
    drop_sum     = {1'b0, drop_count_q} + {6'd0, n_drop};
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Offer/handshake controller
    case (state_q)
      ST_IDLE: begin
        if ((cd_q == 8'd0) && (pending_q != 4'b0000)) begin
          state_d  = ST_OFFER;
          act_id_d = lowest_set(pending_q);
        end
      end
      ST_OFFER: begin
        // act_id_q holds its value here, so the offered id cannot change.
        if (xfer) begin
          state_d = ST_IDLE;
          cd_d    = CD_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values and the update order inside the block is irrelevant.
    if (rst) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      stable_q     <= 4'b0000;
      pending_q    <= 4'b0000;
      state_q      <= ST_IDLE;
      act_id_q     <= 2'd0;
      cd_q         <= 8'd0;
      dropped_q    <= 1'b0;
      drop_count_q <= 8'd0;
      // NOTE: the debounce counters form a small register array, not a RAM.
      // They are cleared on reset so no stale count can flip a button early.
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      act_id_q     <= act_id_d;
      cd_q         <= cd_d;
      dropped_q    <= dropped_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign act.act_valid = (state_q == ST_OFFER);
  assign act.act_id    = act_id_q;
  assign dropped_o     = dropped_q;
  assign drop_count_o  = drop_count_q;
  assign busy_o        = (cd_q != 8'd0);

endmodule : care_action_receiver

// File: tb/tb_care_action_receiver.sv
// ----------------------------------------------------------------------------
// tb_care_action_receiver
// Directed bench for care_action_receiver (DB_CYCLES=8, COOLDOWN=16).
// Stimulus pushes each expected token id into a queue. A monitor pops the
// queue and compares on every transfer. The monitor also tracks dropped
// pulses, valid cycles and id stability while a token is offered.
// ----------------------------------------------------------------------------
module tb_care_action_receiver;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       asleep;
  logic       dropped;
  logic [7:0] drop_count;
  logic       busy;

  care_action_if act_if ();

  care_action_receiver #(
    .DB_CYCLES (8),
    .COOLDOWN  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn),
    .asleep_i     (asleep),
    .act          (act_if.master),
    .dropped_o    (dropped),
    .drop_count_o (drop_count),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int cyc        = 0;
  int valid_seen = 0;
  int drop_seen  = 0;
  int tok_count  = 0;
  logic [1:0] exp_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [1:0] prev_id    = 2'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (act_if.act_valid) valid_seen++;
      if (dropped) drop_seen++;
      if (prev_valid && act_if.act_valid && !prev_xfer)
        check("id_hold", 32'(act_if.act_id), 32'(prev_id));
      if (act_if.act_valid && act_if.act_ready) begin
        tok_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_token actual_id=%0d required=none", act_if.act_id);
        end else begin
          check("token_id", 32'(act_if.act_id), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = act_if.act_valid;
      prev_id    = act_if.act_id;
      prev_xfer  = act_if.act_valid && act_if.act_ready;
    end
  end

  // Advance n rising edges, then settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'b0000;
    act_if.act_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!act_if.act_valid && n < max) begin
      tick(1);
      n++;
    end
    check(name, 32'(act_if.act_valid), 32'd1);
  endtask

  task automatic wait_tokens(input string name, input int target, input int max);
    int n;
    n = 0;
    while (tok_count < target && n < max) begin
      tick(1);
      n++;
    end
    check(name, 32'(tok_count), 32'(target));
  endtask

  task automatic press(input logic [3:0] pattern, input int hold, input int gap);
    btn = pattern;
    tick(hold);
    btn = 4'b0000;
    tick(gap);
  endtask

  initial begin
    int v0, d0, t0, n, r1, r2, r3, exp_drop;

    rst = 1'b1;
    btn = 4'b0000;
    asleep = 1'b0;
    act_if.act_ready = 1'b0;
    tick(2);

    // Reset state
    check("rst_valid", 32'(act_if.act_valid), 32'd0);
    check("rst_id", 32'(act_if.act_id), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(1);

    // ---- Single press: valid rises on edge 11, not before ----
    btn = 4'b0001;
    tick(10);
    check("lat_not_before", 32'(act_if.act_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(act_if.act_valid), 32'd1);
    check("lat_id", 32'(act_if.act_id), 32'd0);
    btn = 4'b0000;
    exp_q.push_back(2'd0);
    act_if.act_ready = 1'b1;
    tick(1);
    act_if.act_ready = 1'b0;
    check("xfer_valid_low", 32'(act_if.act_valid), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick(1);
    end
    check("busy_cycles", 32'(n), 32'd16);
    tick(20);

    // ---- Bounce rejection: 7 high, 1 low, 7 high ----
    v0 = valid_seen;
    d0 = drop_seen;
    btn = 4'b0010; tick(7);
    btn = 4'b0000; tick(1);
    btn = 4'b0010; tick(7);
    btn = 4'b0000; tick(30);
    check("bounce_no_token", 32'(valid_seen - v0), 32'd0);
    check("bounce_no_drop", 32'(drop_seen - d0), 32'd0);
    t0 = tok_count;
    exp_q.push_back(2'd1);
    act_if.act_ready = 1'b1;
    press(4'b0010, 12, 0);
    wait_tokens("bounce_held_token", t0 + 1, 40);
    act_if.act_ready = 1'b0;
    tick(40);

    // ---- Simultaneous presses, ready held high: ids 1, 2, 3 ----
    t0 = tok_count;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    act_if.act_ready = 1'b1;
    btn = 4'b1110;
    wait_valid("simul_first", 20);
    r1 = cyc;
    tick(1);
    wait_valid("simul_second", 40);
    r2 = cyc;
    btn = 4'b0000;
    tick(1);
    wait_valid("simul_third", 40);
    r3 = cyc;
    check("simul_gap_1_2", 32'(r2 - r1), 32'd18);
    check("simul_gap_2_3", 32'(r3 - r2), 32'd18);
    tick(40);
    check("simul_tokens", 32'(tok_count - t0), 32'd3);
    check("simul_pending_clear", 32'(dut.pending_q), 32'd0);
    act_if.act_ready = 1'b0;

    // ---- Overlap drop: second id-2 press while id-2 still offered ----
    do_reset();
    tick(1);
    d0 = drop_seen;
    t0 = tok_count;
    press(4'b0100, 12, 0);
    check("overlap_valid", 32'(act_if.act_valid), 32'd1);
    check("overlap_id_first", 32'(act_if.act_id), 32'd2);
    tick(14);
    press(4'b0100, 12, 14);
    check("overlap_drop_pulses", 32'(drop_seen - d0), 32'd1);
    check("overlap_drop_count", 32'(drop_count), 32'd1);
    check("overlap_id_kept", 32'(act_if.act_id), 32'd2);
    exp_q.push_back(2'd2);
    act_if.act_ready = 1'b1;
    wait_tokens("overlap_token", t0 + 1, 10);
    act_if.act_ready = 1'b0;
    tick(40);
    check("overlap_single_token", 32'(tok_count - t0), 32'd1);

    // ---- Sleep gating ----
    do_reset();
    tick(1);
    asleep = 1'b1;
    v0 = valid_seen;
    d0 = drop_seen;
    press(4'b0010, 12, 14);
    press(4'b1000, 12, 14);
    check("sleep_drop_pulses", 32'(drop_seen - d0), 32'd2);
    check("sleep_drop_count", 32'(drop_count), 32'd2);
    check("sleep_no_token", 32'(valid_seen - v0), 32'd0);
    t0 = tok_count;
    exp_q.push_back(2'd0);
    act_if.act_ready = 1'b1;
    press(4'b0001, 12, 0);
    wait_tokens("sleep_wake_token", t0 + 1, 20);
    act_if.act_ready = 1'b0;
    asleep = 1'b0;
    tick(40);

    // ---- Saturation: 87 triple presses = 261 discards ----
    do_reset();
    tick(1);
    asleep = 1'b1;
    d0 = drop_seen;
    exp_drop = 0;
    for (int k = 0; k < 87; k++) begin
      press(4'b1110, 10, 10);
      exp_drop = (exp_drop + 3 > 255) ? 255 : exp_drop + 3;
      if (k == 40) check("sat_midway", 32'(drop_count), 32'(exp_drop));
    end
    check("sat_drop_count", 32'(drop_count), 32'(exp_drop));
    check("sat_drop_pulses", 32'(drop_seen - d0), 32'd87);
    asleep = 1'b0;
    tick(5);

    // ---- Reset during an offered token: token lost, nothing reappears ----
    btn = 4'b0001;
    wait_valid("rst_mid_valid", 20);
    rst = 1'b1;
    btn = 4'b0000;
    tick(1);
    rst = 1'b0;
    check("rst_mid_valid_low", 32'(act_if.act_valid), 32'd0);
    check("rst_mid_id", 32'(act_if.act_id), 32'd0);
    check("rst_mid_dropped", 32'(dropped), 32'd0);
    check("rst_mid_drop_count", 32'(drop_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    v0 = valid_seen;
    tick(40);
    check("rst_mid_no_reappear", 32'(valid_seen - v0), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit reached");
  end

endmodule : tb_care_action_receiver
